// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-enable generator.
package clk_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_PEND = 2'd2
  } div_state_t;

  localparam int unsigned CLK_DIV_DEFAULT_W = 32;
  localparam int unsigned CLK_DIV_SYS_HZ    = 300_000_000;

endpackage

// File: rtl/clk_div_counter.sv
// Wrapping 0..div-1 counter with terminal-count flag; held at 0 while not running.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CLK_DIV_DEFAULT_W
) (
  input  logic             sys_clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] count,
  output logic             tc_c
);

  assign tc_c = (count == (div - CNT_W'(1)));

  always_ff @(posedge sys_clock) begin
    if (!reset_n || !run) begin
      count <= '0;
    end else if (tc_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_enable_gen.sv
// Runtime-programmable clock-enable generator with shadowed divisor reload.
// Optional legacy divided-clock output enabled by CLKEN_DIVCLK_OUT_EN.
module clock_enable_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned     CNT_W       = CLK_DIV_DEFAULT_W,
  parameter longint unsigned DEFAULT_DIV = 64'd75_000_000
) (
  input  logic             sys_clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_value,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_busy,
  output logic             div_err,
  output logic             ce_out
`ifdef CLKEN_DIVCLK_OUT_EN
  ,
  output logic             divided_clock
`endif
);

  if ((DEFAULT_DIV == 64'd0) || (DEFAULT_DIV > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_default
    $error("clock_enable_gen: DEFAULT_DIV outside 1 .. 2^CNT_W-1");
  end

  div_state_t       state, state_d;
  logic [CNT_W-1:0] active_div, active_d;
  logic [CNT_W-1:0] shadow, shadow_d;
  logic [CNT_W-1:0] count;
  logic             tc_c;
  logic             ack_d, busy_d, err_d;
  logic             err_pend, err_pend_d;
  logic             load_ok, load_zero, err_c;

  clk_div_counter #(.CNT_W(CNT_W)) u_cnt (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .run       (enable),
    .div       (active_div),
    .count     (count),
    .tc_c      (tc_c)
  );

  // Next-state, divisor/shadow update and handshake pulses
  always_comb begin
    state_d    = state;
    active_d   = active_div;
    shadow_d   = shadow;
    ack_d      = 1'b0;
    load_ok    = div_load && (div_value != '0);
    load_zero  = div_load && (div_value == '0);
    case (state)
      DIV_IDLE: begin
        if (load_ok) begin
          active_d = div_value;
          ack_d    = 1'b1;
        end
        if (enable) state_d = DIV_RUN;
      end
      DIV_RUN: begin
        if (!enable) begin
          state_d = DIV_IDLE;
          if (load_ok) begin
            active_d = div_value;
            ack_d    = 1'b1;
          end
        end else if (load_ok) begin
          shadow_d = div_value;
          state_d  = DIV_PEND;
        end
      end
      DIV_PEND: begin
        if (!enable) begin
          active_d = load_ok ? div_value : shadow;
          ack_d    = 1'b1;
          state_d  = DIV_IDLE;
        end else begin
          if (tc_c) begin
            active_d = shadow;
            ack_d    = 1'b1;
            state_d  = DIV_RUN;
          end
          // a load landing on the boundary waits for the next one
          if (load_ok) begin
            shadow_d = div_value;
            state_d  = DIV_PEND;
          end
        end
      end
      default: state_d = DIV_IDLE;
    endcase
    busy_d     = (state_d == DIV_PEND);
    // an error colliding with an ack is deferred one cycle so they never overlap
    err_c      = load_zero | err_pend;
    err_d      = err_c & ~ack_d;
    err_pend_d = err_c & ack_d;
  end

  always_ff @(posedge sys_clock) begin
    if (!reset_n) begin
      state      <= DIV_IDLE;
      active_div <= CNT_W'(DEFAULT_DIV);
      shadow     <= '0;
      div_ack    <= 1'b0;
      div_busy   <= 1'b0;
      div_err    <= 1'b0;
      err_pend   <= 1'b0;
      ce_out     <= 1'b0;
    end else begin
      state      <= state_d;
      active_div <= active_d;
      shadow     <= shadow_d;
      div_ack    <= ack_d;
      div_busy   <= busy_d;
      div_err    <= err_d;
      err_pend   <= err_pend_d;
      ce_out     <= enable & tc_c;
    end
  end

`ifdef CLKEN_DIVCLK_OUT_EN
  always_ff @(posedge sys_clock) begin
    if (!reset_n) begin
      divided_clock <= 1'b0;
    end else if (enable && tc_c) begin
      divided_clock <= ~divided_clock;
    end
  end
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench for clock_enable_gen with CNT_W=8, DEFAULT_DIV=5.
module tb_clock_enable_gen;
  import clk_div_pkg::*;

  localparam int unsigned     CNT_W       = 8;
  localparam longint unsigned DEFAULT_DIV = 64'd5;

  logic             sys_clock = 1'b0;
  logic             reset_n   = 1'b0;
  logic             enable    = 1'b0;
  logic             div_load  = 1'b0;
  logic [CNT_W-1:0] div_value = '0;
  logic             div_ack, div_busy, div_err, ce_out;
`ifdef CLKEN_DIVCLK_OUT_EN
  logic             divided_clock;
  logic             dc_exp = 1'b0;
`endif

  typedef struct {
    int   at;
    logic ce;
    logic ack;
    logic err;
    logic busy;
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  t;

  clock_enable_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .sys_clock     (sys_clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .div_value     (div_value),
    .div_load      (div_load),
    .div_ack       (div_ack),
    .div_busy      (div_busy),
    .div_err       (div_err),
    .ce_out        (ce_out)
`ifdef CLKEN_DIVCLK_OUT_EN
    ,
    .divided_clock (divided_clock)
`endif
  );

  always #5 sys_clock = ~sys_clock;

  always @(posedge sys_clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input int at, input logic ce, input logic ack, input logic err, input logic busy);
    exp_q.push_back('{at, ce, ack, err, busy});
  endtask

  // Monitor: every output pulse must match the next queued expectation
  initial begin
    ev_t e;
    forever begin
      @(negedge sys_clock);
`ifdef CLKEN_DIVCLK_OUT_EN
      if (!reset_n) dc_exp = 1'b0;
`endif
      if (reset_n && (ce_out || div_ack || div_err)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: cycle %0d ce/ack/err/busy=%b%b%b%b, expected none",
                   cyc, ce_out, div_ack, div_err, div_busy);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (e.at == cyc && e.ce === ce_out && e.ack === div_ack &&
              e.err === div_err && e.busy === div_busy)
            n_pass++;
          else
            $display("FAIL event: cycle %0d ce/ack/err/busy=%b%b%b%b, expected cycle %0d %b%b%b%b",
                     cyc, ce_out, div_ack, div_err, div_busy, e.at, e.ce, e.ack, e.err, e.busy);
        end
`ifdef CLKEN_DIVCLK_OUT_EN
        if (ce_out) begin
          dc_exp = ~dc_exp;
          chk("divided_clock", 32'(divided_clock), 32'(dc_exp));
        end
`endif
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_ce_out",   32'(ce_out),   32'd0);
    chk("rst_div_ack",  32'(div_ack),  32'd0);
    chk("rst_div_busy", 32'(div_busy), 32'd0);
    chk("rst_div_err",  32'(div_err),  32'd0);
`ifdef CLKEN_DIVCLK_OUT_EN
    chk("rst_divided_clock", 32'(divided_clock), 32'd0);
`endif

    // default divisor 5, then load 2 at counter=1
    t = cyc;
    reset_n = 1'b1;
    enable  = 1'b1;
    push(t+5,  1, 0, 0, 0);
    push(t+10, 1, 0, 0, 0);
    push(t+15, 1, 0, 0, 0);
    tick(16);
    div_value = 8'd2;
    div_load  = 1'b1;
    push(t+20, 1, 1, 0, 0);
    push(t+22, 1, 0, 0, 0);
    push(t+24, 1, 0, 0, 0);
    push(t+26, 1, 0, 0, 1);
    push(t+28, 1, 1, 0, 0);
    push(t+32, 1, 0, 0, 0);
    push(t+34, 0, 0, 1, 0);
    push(t+36, 1, 0, 0, 0);
    tick(1);
    div_load = 1'b0;
    chk("busy_pending", 32'(div_busy), 32'd1);

    // load 7 on a terminal-count edge, overwritten by 4 before the next one
    tick(8);
    div_value = 8'd7;
    div_load  = 1'b1;
    tick(1);
    div_value = 8'd4;
    tick(1);
    div_load = 1'b0;

    // zero divisor is rejected
    tick(6);
    div_value = 8'd0;
    div_load  = 1'b1;
    tick(1);
    div_load = 1'b0;

    // reset while a load is pending
    tick(2);
    div_value = 8'd3;
    div_load  = 1'b1;
    tick(1);
    div_load = 1'b0;
    reset_n  = 1'b0;
    tick(2);
    chk("rst_pend_busy",  32'(div_busy),       32'd0);
    chk("rst_pend_ack",   32'(div_ack),        32'd0);
    chk("rst_pend_state", 32'(dut.state),      32'(DIV_IDLE));
    chk("rst_pend_div",   32'(dut.active_div), 32'd5);
    reset_n = 1'b1;
    push(t+44, 1, 0, 0, 0);
    push(t+49, 1, 0, 0, 0);

    // drop enable mid-count
    tick(12);
    enable = 1'b0;
    tick(1);
    chk("disable_count", 32'(dut.u_cnt.count), 32'd0);
    chk("disable_state", 32'(dut.state),       32'(DIV_IDLE));

    // N=1 loaded in idle: ce every cycle
    div_value = 8'd1;
    div_load  = 1'b1;
    push(t+53, 0, 1, 0, 0);
    tick(1);
    div_load = 1'b0;
    enable   = 1'b1;
    for (int k = 54; k <= 60; k++) push(t+k, 1, 0, 0, 0);
    tick(7);
    enable = 1'b0;
    tick(5);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
